// File: rtl/hash_pkg.sv
// Shared types and constants for the hash core byte-input transmitter.
// Imported by hash_stream_tx and its word serializer.
package hash_pkg;

    localparam int DIGEST_W = 32;
    localparam int BYTE_W   = 8;
    localparam int WORD_B   = DIGEST_W / BYTE_W;

    localparam logic [DIGEST_W-1:0] HASH_IV = 32'h32FE1AF3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_DIG,
        ST_OUT
    } hstx_state_t;

endpackage

// File: rtl/word_to_bytes.sv
// Word serializer: 32-bit shift register, byte 0 first,
// with a saturating 2-bit byte index.
module word_to_bytes
    import hash_pkg::*;
(
    input  logic                clock,
    input  logic                rstn,
    input  logic                load,
    input  logic                shift,
    input  logic [DIGEST_W-1:0] word_in,
    output logic [BYTE_W-1:0]   byte_out,
    output logic                last_in_word
);

    logic [DIGEST_W-1:0] sh;
    logic [1:0]          idx;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            sh  <= '0;
            idx <= '0;
        end else if (load) begin
            sh  <= word_in;
            idx <= '0;
        end else if (shift) begin
            sh <= sh >> BYTE_W;
            if (idx != 2'd3)
                idx <= idx + 2'd1;
        end
    end

    assign byte_out     = sh[BYTE_W-1:0];
    assign last_in_word = (idx == 2'd3);

endmodule

// File: rtl/hash_stream_tx.sv
// Host-side transmitter: serializes message words into the hash core
// byte port, then returns the captured digest over valid/ready.
module hash_stream_tx
    import hash_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic                clock,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                word_valid,
    output logic                word_ready,
    input  logic [DIGEST_W-1:0] word_data,
    output logic                hash_start,
    output logic [LEN_W-1:0]    hash_len,
    output logic [BYTE_W-1:0]   hash_byte,
    output logic                hash_byte_valid,
    input  logic                hash_byte_ready,
    input  logic [DIGEST_W-1:0] hash_digest,
    input  logic                hash_digest_valid,
    output logic                dig_valid,
    input  logic                dig_ready,
    output logic [DIGEST_W-1:0] dig_data,
    output logic                busy
);

    hstx_state_t state;
    hstx_state_t state_nxt;

    logic [LEN_W-1:0]  rem;
    logic [BYTE_W-1:0] byte_out;
    logic              last_in_word;
    logic              cmd_hs;
    logic              word_hs;
    logic              byte_hs;
    logic              dig_cap;
    logic              rem_zero;
    logic              rem_one;

    assign cmd_hs   = (state == ST_IDLE) && cmd_valid;
    assign word_hs  = (state == ST_LOAD) && word_valid;
    assign byte_hs  = (state == ST_SEND) && hash_byte_ready;
    assign dig_cap  = (state == ST_WAIT_DIG) && hash_digest_valid;
    assign rem_zero = (rem == '0);
    assign rem_one  = (rem == LEN_W'(1));

    word_to_bytes u_w2b (
        .clock        (clock),
        .rstn         (rstn),
        .load         (word_hs),
        .shift        (byte_hs),
        .word_in      (word_data),
        .byte_out     (byte_out),
        .last_in_word (last_in_word)
    );

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid)
                    state_nxt = ST_START;
            end
            ST_START: begin
                state_nxt = rem_zero ? ST_WAIT_DIG : ST_LOAD;
            end
            ST_LOAD: begin
                if (word_valid)
                    state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // Final byte wins over word boundary: leftover bytes are dropped.
                if (hash_byte_ready) begin
                    if (rem_one)
                        state_nxt = ST_WAIT_DIG;
                    else if (last_in_word)
                        state_nxt = ST_LOAD;
                end
            end
            ST_WAIT_DIG: begin
                if (hash_digest_valid)
                    state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (dig_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rem      <= '0;
            hash_len <= '0;
        end else if (cmd_hs) begin
            rem      <= cmd_len;
            hash_len <= cmd_len;
        end else if (byte_hs && !rem_zero) begin
            rem <= rem - LEN_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)
            dig_data <= '0;
        else if (dig_cap)
            dig_data <= hash_digest;
    end

    assign cmd_ready       = (state == ST_IDLE);
    assign hash_start      = (state == ST_START);
    assign word_ready      = (state == ST_LOAD);
    assign hash_byte_valid = (state == ST_SEND);
    assign hash_byte       = (state == ST_SEND) ? byte_out : '0;
    assign dig_valid       = (state == ST_OUT);
    assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_hash_stream_tx.sv
// Scoreboard bench for hash_stream_tx: directed messages, monitor
// pops expected bytes and digests on every output handshake.
module tb_hash_stream_tx;
    import hash_pkg::*;

    logic        clock = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_len = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [31:0] word_data = '0;
    logic        hash_start;
    logic [31:0] hash_len;
    logic [7:0]  hash_byte;
    logic        hash_byte_valid;
    logic        hash_byte_ready = 1'b1;
    logic [31:0] hash_digest = '0;
    logic        hash_digest_valid = 1'b0;
    logic        dig_valid;
    logic        dig_ready = 1'b0;
    logic [31:0] dig_data;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int whs = 0;
    int bytes_total = 0;
    int dv_total = 0;
    bit rnd = 1'b0;
    bit abort = 1'b0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_dig[$];

    hash_stream_tx #(.LEN_W(32)) dut (
        .clock             (clock),
        .rstn              (rstn),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_len           (cmd_len),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .word_data         (word_data),
        .hash_start        (hash_start),
        .hash_len          (hash_len),
        .hash_byte         (hash_byte),
        .hash_byte_valid   (hash_byte_valid),
        .hash_byte_ready   (hash_byte_ready),
        .hash_digest       (hash_digest),
        .hash_digest_valid (hash_digest_valid),
        .dig_valid         (dig_valid),
        .dig_ready         (dig_ready),
        .dig_data          (dig_data),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endfunction

    function automatic void fail(string n);
        checks++;
        failures++;
        $display("FAIL %s got=timeout/unexpected exp=handshake", n);
    endfunction

    initial forever begin
        @(posedge clock);
        #1 hash_byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: counts events and pops the scoreboard on handshakes.
    initial begin
        bit          prev_stall;
        logic [7:0]  prev_byte;
        bit          prev_dv;
        logic [31:0] prev_dd;
        logic [7:0]  eb;
        logic [31:0] ed;
        prev_stall = 0;
        prev_dv = 0;
        prev_byte = '0;
        prev_dd = '0;
        forever begin
            @(negedge clock);
            if (!rstn) begin
                prev_stall = 0;
                prev_dv = 0;
            end else begin
                if (hash_start) starts++;
                if (word_valid && word_ready) whs++;
                if (dig_valid) dv_total++;
                if (prev_stall)
                    chk("byte_hold", 32'({hash_byte_valid, hash_byte}),
                        32'({1'b1, prev_byte}));
                if (hash_byte_valid && hash_byte_ready) begin
                    bytes_total++;
                    if (exp_bytes.size() == 0) begin
                        fail("extra_byte");
                    end else begin
                        eb = exp_bytes.pop_front();
                        chk("byte", 32'(hash_byte), 32'(eb));
                    end
                end
                prev_stall = hash_byte_valid && !hash_byte_ready;
                prev_byte = hash_byte;
                if (prev_dv && dig_valid)
                    chk("dig_stable", dig_data, prev_dd);
                if (dig_valid)
                    chk("cmd_ready_in_out", 32'(cmd_ready), 32'd0);
                if (dig_valid && dig_ready) begin
                    if (exp_dig.size() == 0) begin
                        fail("extra_digest");
                    end else begin
                        ed = exp_dig.pop_front();
                        chk("digest", dig_data, ed);
                    end
                end
                prev_dv = dig_valid;
                prev_dd = dig_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic feed(input logic [31:0] w0, w1, w2, input int n);
        logic [31:0] ws[3];
        int k;
        ws[0] = w0;
        ws[1] = w1;
        ws[2] = w2;
        for (int i = 0; i < n; i++) begin
            word_valid = 1'b1;
            word_data = ws[i];
            k = 0;
            while (!word_ready && !abort && k < 300) begin
                @(negedge clock);
                k++;
            end
            if (abort) begin
                word_valid = 1'b0;
                return;
            end
            if (!word_ready) begin
                fail("word_timeout");
                word_valid = 1'b0;
                return;
            end
            @(posedge clock);
            #1 word_valid = 1'b0;
        end
    endtask

    task automatic push_bytes(input int len, input logic [31:0] w0, w1, w2);
        logic [31:0] ws[3];
        ws[0] = w0;
        ws[1] = w1;
        ws[2] = w2;
        for (int i = 0; i < len; i++)
            exp_bytes.push_back(8'(ws[i / 4] >> (8 * (i % 4))));
    endtask

    task automatic send_cmd(input int len, output time t);
        int k;
        t = 0;
        cmd_valid = 1'b1;
        cmd_len = len;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (!cmd_ready) begin
            fail("cmd_timeout");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        t = $time;
        #1 cmd_valid = 1'b0;
        #2;
        chk("hash_start", 32'(hash_start), 32'd1);
        chk("cmd_ready_busy", 32'({cmd_ready, busy}), 32'b01);
        chk("hash_len", hash_len, len);
        @(posedge clock);
        #3;
        chk("start_once", 32'(hash_start), 32'd0);
        chk("word_ready_lat", 32'(word_ready), 32'(len != 0));
    endtask

    task automatic finish_digest(input int len, input logic [31:0] d,
                                 input int dly, output time t);
        int k;
        int dv0;
        t = 0;
        k = 0;
        while (!(busy && !hash_byte_valid && !word_ready && !hash_start &&
                 exp_bytes.size() == 0) && k < 500) begin
            @(negedge clock);
            k++;
        end
        if (k >= 500) fail("bytes_timeout");
        chk("len_held", hash_len, len);
        @(posedge clock);
        #1 hash_digest = d;
        hash_digest_valid = 1'b1;
        exp_dig.push_back(d);
        @(posedge clock);
        #1 hash_digest_valid = 1'b0;
        dv0 = dv_total;
        #2;
        chk("dig_latency", 32'({dig_valid, word_ready}), 32'b10);
        chk("dig_data_early", dig_data, d);
        for (int i = 0; i < dly; i++) begin
            @(posedge clock);
            #1;
        end
        dig_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (dig_valid && k < 100);
        dig_ready = 1'b0;
        t = $time - 5;
        if (dig_valid) fail("dig_timeout");
        chk("dig_valid_cycles", dv_total - dv0, dly + 1);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_msg(input int len, input logic [31:0] w0, w1, w2,
                           input logic [31:0] d, input int dly, input bit r,
                           output time t_cmd, output time t_dig);
        int s0, w_0, b0;
        s0 = starts;
        w_0 = whs;
        b0 = bytes_total;
        push_bytes(len, w0, w1, w2);
        rnd = r;
        fork
            feed(w0, w1, w2, (len + 3) / 4);
        join_none
        send_cmd(len, t_cmd);
        finish_digest(len, d, dly, t_dig);
        wait fork;
        rnd = 1'b0;
        chk("start_count", starts - s0, 1);
        chk("word_count", whs - w_0, (len + 3) / 4);
        chk("byte_count", bytes_total - b0, len);
        chk("queue_empty", exp_bytes.size(), 0);
    endtask

    initial begin
        time tc, td, tc2, td2;
        int b0;
        repeat (3) @(posedge clock);
        #1 rstn = 1'b1;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_ctrl", 32'({hash_start, hash_byte_valid, word_ready,
                             dig_valid, busy}), 32'd0);
        chk("rst_data", 32'(hash_byte) | hash_len | dig_data, 32'd0);
        @(posedge clock);
        #1 hash_digest = 32'h12345678;
        hash_digest_valid = 1'b1;
        @(posedge clock);
        #1 hash_digest_valid = 1'b0;
        #2;
        chk("idle_dig_ignored", 32'({dig_valid, busy}), 32'd0);
        chk("idle_dig_data", dig_data, 32'd0);

        run_msg(5, 32'h44332211, 32'h000000AA, 32'h0,
                32'hDEADBEEF, 0, 1'b0, tc, td);
        run_msg(0, 32'h0, 32'h0, 32'h0, HASH_IV, 0, 1'b0, tc, td);
        run_msg(8, 32'h04030201, 32'h08070605, 32'h0,
                32'hCAFEF00D, 9, 1'b1, tc, td);

        // Reset while the third byte of a 12-byte message is offered.
        b0 = bytes_total;
        push_bytes(12, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211);
        fork
            feed(32'h0C0B0A09, 32'h100F0E0D, 32'h14131211, 3);
        join_none
        send_cmd(12, tc);
        while (bytes_total - b0 < 2 && $time < tc + 2000)
            @(negedge clock);
        chk("pre_reset_bytes", bytes_total - b0, 2);
        @(posedge clock);
        #1 rstn = 1'b0;
        abort = 1'b1;
        exp_bytes.delete();
        #2;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_ctrl", 32'({hash_start, hash_byte_valid, word_ready,
                                 dig_valid, busy}), 32'd0);
        chk("mid_rst_data", 32'(hash_byte) | hash_len | dig_data, 32'd0);
        wait fork;
        @(posedge clock);
        #1 rstn = 1'b1;
        abort = 1'b0;
        #2;
        chk("post_rst_start", 32'({hash_start, cmd_ready}), 32'b01);
        run_msg(4, 32'hA4A3A2A1, 32'h0, 32'h0,
                32'h0BADC0DE, 0, 1'b0, tc, td);

        run_msg(3, 32'hDDCCBBAA, 32'h0, 32'h0,
                32'h11112222, 0, 1'b0, tc, td);
        run_msg(4, 32'h87654321, 32'h0, 32'h0,
                32'h33334444, 0, 1'b0, tc2, td2);
        chk("b2b_gap", 32'(tc2 - td), 32'd10);

        repeat (3) @(posedge clock);
        chk("digest_queue_empty", exp_dig.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_stream_tx.md
# hash_stream_tx

Host-side transmitter for the hash core's byte-input port. It accepts a message command (byte length) and a stream of 32-bit message words from the host. It serializes the words into bytes, issues the start pulse and the byte handshake toward the hash controller/datapath, then captures the 32-bit digest and returns it to the host over a valid/ready output. It sits between the host bus adapter and the hash top-level.

## Interface
Parameters:
- LEN_W, 32, width of the message byte-length field.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rstn  in  1  reset: asynchronous, active-low.
- cmd_valid  in  1  host offers a new message command.
- cmd_ready  out  1  command accepted when both high; high only in IDLE.
- cmd_len  in  LEN_W  message length in bytes; 0 is legal.
- word_valid  in  1  host offers a message word.
- word_ready  out  1  word accepted when both high; high only in LOAD.
- word_data  in  32  message word; byte 0 = [7:0], byte 3 = [31:24].
- hash_start  out  1  one-cycle pulse that restarts the core (IV reload, counter clear).
- hash_len  out  LEN_W  latched cmd_len; stable from hash_start until return to IDLE.
- hash_byte  out  8  current message byte.
- hash_byte_valid  out  1  byte offered to the core.
- hash_byte_ready  in  1  core consumes the byte when both high.
- hash_digest  in  32  core digest value.
- hash_digest_valid  in  1  one-cycle pulse; digest is final.
- dig_valid  out  1  digest available to the host.
- dig_ready  in  1  host consumes the digest.
- dig_data  out  32  captured digest.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, LOAD, SEND, WAIT_DIG, OUT. Reset puts the block in IDLE.
- IDLE: cmd_ready=1. On a cmd handshake: latch cmd_len into hash_len and rem, then go to START.
- START: hash_start=1 for exactly one cycle. Next state is WAIT_DIG if rem==0, else LOAD.
- LOAD: word_ready=1. On a word handshake: load shift register sh, set idx=0, go to SEND.
- SEND: hash_byte=sh[7:0], hash_byte_valid=1. On a byte handshake:
  - sh shifts right by 8, idx increments, rem decrements.
  - If rem was 1, go to WAIT_DIG. Unused bytes of a partial last word are discarded.
  - Else if idx was 3, go to LOAD.
  - Else stay in SEND.
- While hash_byte_ready is low, hash_byte and hash_byte_valid hold. The byte is never withdrawn.
- WAIT_DIG: on hash_digest_valid, capture hash_digest into dig_data and go to OUT. A hash_digest_valid pulse in any other state is ignored.
- OUT: dig_valid=1, dig_data stable. On dig_ready, go to IDLE.
- rem and idx never wrap: rem is checked before decrement, idx ranges 0..3.
- Word count consumed = ceil(cmd_len/4). The block never requests extra words.

## Timing
- Reset values: cmd_ready=1 (IDLE); hash_start, hash_byte_valid, word_ready, dig_valid, busy = 0; hash_byte, hash_len, dig_data = 0.
- hash_start is asserted 1 cycle after the cmd handshake.
- The first word_ready is asserted 2 cycles after the cmd handshake.
- The first hash_byte_valid is asserted 1 cycle after the word handshake. There is one bubble cycle per word (SEND→LOAD→SEND).
- With ready always high, byte throughput is 4 bytes per 5 cycles.
- dig_valid is asserted 1 cycle after the hash_digest_valid pulse.
- cmd_ready is low from the cmd handshake until the cycle after dig_ready. Back-to-back messages therefore have a 1-cycle IDLE gap.
- All handshake outputs are decoded from registered state; no combinational path from any *_ready to any *_valid.
- Reset mid-message: the block returns to IDLE immediately. No hash_start is issued by reset; the next command restarts the core.

## Structure
- The shared package hash_pkg holds:
  - state enum hstx_state_t;
  - DIGEST_W=32 and BYTE_W=8;
  - HASH_IV=32'h32FE1AF3, used by the bench model.
- One sub-module, word_to_bytes: the 32-bit shift register plus 2-bit idx, with ports load, shift, last_in_word and byte_out.
- The FSM, rem counter and digest register stay in hash_stream_tx.

## Test plan
- Reset, then idle: cmd_ready=1 and all other outputs 0. A hash_digest_valid pulse in IDLE leaves dig_valid=0.
- cmd_len=5, words 32'h44332211 and 32'h000000AA, all readies high → one hash_start; bytes 11,22,33,44,AA in order; exactly 2 word handshakes. A core-stub digest 32'hDEADBEEF appears on dig_data 1 cycle after its pulse.
- cmd_len=0 → hash_start, no word_ready, no hash_byte_valid. Stub digest 32'h32FE1AF3 is returned.
- cmd_len=8, hash_byte_ready toggled randomly and dig_ready delayed 10 cycles → hash_byte is stable while stalled; 8 bytes are delivered; dig_valid holds 10 cycles; cmd_ready rises only after dig_ready.
- rstn low during the 3rd byte of a cmd_len=12 message → IDLE and reset values are restored. A new cmd_len=4 run completes normally with a single hash_start.
- Two back-to-back commands (len 3, then len 4) → the second is accepted 1 cycle after the first digest handshake. Correct byte streams for both; bytes 4 of word 0 of message 1 are never sent.
